// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: memory-port and row-engine handshake bundle between sweep_ctrl (master)
// and the row memory / window / evaluation engine side (slave).
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

interface sweep_ctrl_if #(
    parameter int ADDR_W = `BANK_ADDR_WIDTH,
    parameter int CNT_W  = 8
);
    logic              mem_req_out;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_row_out;
    logic              mem_ack_in;
    logic              mem_busy_in;
    logic              win_shift_out;
    logic              win_zero_out;
    logic              eval_start_out;
    logic              eval_done_in;
    logic              eval_changed_in;
    logic [CNT_W-1:0]  eval_count_in;

    modport master (
        output mem_req_out, mem_we_out, mem_row_out,
        output win_shift_out, win_zero_out, eval_start_out,
        input  mem_ack_in, mem_busy_in,
        input  eval_done_in, eval_changed_in, eval_count_in
    );

    modport slave (
        input  mem_req_out, mem_we_out, mem_row_out,
        input  win_shift_out, win_zero_out, eval_start_out,
        output mem_ack_in, mem_busy_in,
        output eval_done_in, eval_changed_in, eval_count_in
    );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: walks a row memory top to bottom through a 3-row window, evaluates each middle row and
// writes it back. Define SWEEP_UNTIL_STABLE_EN to repeat passes until a pass reports no change.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif
`ifndef BANK_DEPTH
`define BANK_DEPTH (1 << `BANK_ADDR_WIDTH)
`endif

module sweep_ctrl #(
    parameter int ROWS  = `BANK_DEPTH,
    parameter int CNT_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      run_in,
    input  logic [`BANK_ADDR_WIDTH:0] rows_in,
    sweep_ctrl_if.master              bus,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [31:0]               updates_out,
    output logic [15:0]               pass_cnt_out
);
    localparam int AW = `BANK_ADDR_WIDTH;
    localparam logic [AW:0] ROWS_MAX = ROWS[AW:0];

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRIME   = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_EVAL    = 3'd3;
    localparam logic [2:0] S_WBACK   = 3'd4;
    localparam logic [2:0] S_ENDPASS = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    r_state;
    logic [AW:0]   r_rows;
    logic [AW-1:0] r_cur;
    logic [AW-1:0] r_row;
    logic          r_we;
    logic          r_need;
    logic          r_req;
    logic          r_gap;
    logic          r_zero;
    logic          r_eval_start;
    logic          r_busy;
    logic          r_done;
    logic [31:0]   r_updates;
    logic [15:0]   r_pass;
`ifdef SWEEP_UNTIL_STABLE_EN
    logic          r_changed;
`endif

    logic             w_launch;
    logic             w_ack;
    logic [AW:0]      w_cur_p1;
    logic [AW:0]      w_cur_p2;
    logic             w_last;
    logic [AW:0]      w_rows_clamped;
    logic [CNT_W-1:0] w_count;

    // A pending request launches only while memory is free, and never in the cycle right after an ack
    // so every request visibly drops before the next one starts.
    assign w_launch       = r_need & ~bus.mem_busy_in & ~r_gap;
    assign w_ack          = r_req & bus.mem_ack_in;
    assign w_cur_p1       = {1'b0, r_cur} + 1'b1;
    assign w_cur_p2       = {1'b0, r_cur} + 2'd2;
    assign w_last         = (w_cur_p1 == r_rows);
    assign w_rows_clamped = (rows_in > ROWS_MAX) ? ROWS_MAX : rows_in;
    assign w_count        = bus.eval_count_in;

    assign bus.mem_req_out    = r_req | w_launch;
    assign bus.mem_we_out     = r_we;
    assign bus.mem_row_out    = r_row;
    assign bus.win_shift_out  = w_ack & ~r_we;
    assign bus.win_zero_out   = r_zero;
    assign bus.eval_start_out = r_eval_start;
    assign busy_out           = r_busy;
    assign done_out           = r_done;
    assign updates_out        = r_updates;
    assign pass_cnt_out       = r_pass;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rows       <= '0;
            r_cur        <= '0;
            r_row        <= '0;
            r_we         <= 1'b0;
            r_need       <= 1'b0;
            r_req        <= 1'b0;
            r_gap        <= 1'b0;
            r_zero       <= 1'b0;
            r_eval_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_updates    <= '0;
            r_pass       <= '0;
`ifdef SWEEP_UNTIL_STABLE_EN
            r_changed    <= 1'b0;
`endif
        end else begin
            r_zero       <= 1'b0;
            r_eval_start <= 1'b0;
            r_gap        <= 1'b0;
            if (w_launch) begin
                r_need <= 1'b0;
                r_req  <= 1'b1;
            end
            if (w_ack) begin
                r_req <= 1'b0;
                r_gap <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (run_in) begin
                        r_updates <= '0;
                        r_pass    <= '0;
                        r_rows    <= w_rows_clamped;
                        r_cur     <= '0;
`ifdef SWEEP_UNTIL_STABLE_EN
                        r_changed <= 1'b0;
`endif
                        if (w_rows_clamped == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_PRIME;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_zero  <= 1'b1;
                            r_need  <= 1'b1;
                            r_row   <= '0;
                            r_we    <= 1'b0;
                        end
                    end
                end
                S_PRIME: begin
                    if (w_ack) begin
                        r_state <= S_FETCH;
                        if (w_cur_p1 < r_rows) begin
                            r_need <= 1'b1;
                            r_row  <= w_cur_p1[AW-1:0];
                            r_we   <= 1'b0;
                        end else begin
                            r_zero <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    // The bottom row has no successor: its pad was pushed on entry, so go straight on.
                    if (w_last || w_ack) begin
                        r_state      <= S_EVAL;
                        r_eval_start <= 1'b1;
                    end
                end
                S_EVAL: begin
                    if (bus.eval_done_in) begin
                        r_updates <= r_updates + 32'(w_count);
`ifdef SWEEP_UNTIL_STABLE_EN
                        r_changed <= r_changed | bus.eval_changed_in;
`endif
                        r_state   <= S_WBACK;
                        r_need    <= 1'b1;
                        r_row     <= r_cur;
                        r_we      <= 1'b1;
                    end
                end
                S_WBACK: begin
                    if (w_ack) begin
                        if (w_last) begin
                            r_state <= S_ENDPASS;
                        end else begin
                            r_state <= S_FETCH;
                            r_cur   <= w_cur_p1[AW-1:0];
                            if (w_cur_p2 < r_rows) begin
                                r_need <= 1'b1;
                                r_row  <= w_cur_p2[AW-1:0];
                                r_we   <= 1'b0;
                            end else begin
                                r_zero <= 1'b1;
                            end
                        end
                    end
                end
                S_ENDPASS: begin
                    if (r_pass != 16'hFFFF) begin
                        r_pass <= r_pass + 16'd1;
                    end
`ifdef SWEEP_UNTIL_STABLE_EN
                    r_changed <= 1'b0;
                    if (r_changed) begin
                        r_state <= S_PRIME;
                        r_cur   <= '0;
                        r_zero  <= 1'b1;
                        r_need  <= 1'b1;
                        r_row   <= '0;
                        r_we    <= 1'b0;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
`else
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed bench for sweep_ctrl with a memory/engine responder and an event scoreboard.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

module tb_sweep_ctrl;
    localparam int AW = `BANK_ADDR_WIDTH;
    localparam int CW = 8;
`ifdef SWEEP_UNTIL_STABLE_EN
    localparam int MULTI = 1;
`else
    localparam int MULTI = 0;
`endif

    localparam int EV_ZERO  = 32'h100;
    localparam int EV_READ  = 32'h200;
    localparam int EV_WRITE = 32'h300;
    localparam int EV_SHIFT = 32'h400;
    localparam int EV_EVAL  = 32'h500;

    logic          clock = 1'b0;
    logic          reset;
    logic          run_in;
    logic [AW:0]   rows_in;
    logic          busy_out;
    logic          done_out;
    logic [31:0]   updates_out;
    logic [15:0]   pass_cnt_out;

    sweep_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    sweep_ctrl #(.ROWS(1 << AW), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .run_in       (run_in),
        .rows_in      (rows_in),
        .bus          (bus),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .updates_out  (updates_out),
        .pass_cnt_out (pass_cnt_out)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          exp_q[$];
    int          n_reads = 0;
    int          n_writes = 0;
    int          ack_delay = 1;
    logic        stray_ack = 1'b0;
    logic        stray_eval = 1'b0;
    logic [CW-1:0] cnt_first = '0;
    logic        chg_first = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_ev(input string tag, input int ev);
        int e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        check(tag, ev, e);
    endtask

    // Expected window/memory event order of one full pass over n rows.
    task automatic push_pass(input int n);
        exp_q.push_back(EV_ZERO);
        exp_q.push_back(EV_READ + 0);
        exp_q.push_back(EV_SHIFT);
        for (int r = 0; r < n; r++) begin
            if (r + 1 < n) begin
                exp_q.push_back(EV_READ + r + 1);
                exp_q.push_back(EV_SHIFT);
            end else begin
                exp_q.push_back(EV_ZERO);
            end
            exp_q.push_back(EV_EVAL);
            exp_q.push_back(EV_WRITE + r);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done_out && n < budget) begin
            cyc(1);
            n++;
        end
        check({tag, "_done"}, done_out, 1);
    endtask

    // Memory responder: acks a request after it has been visible for ack_delay+1 cycles.
    initial begin
        int waited;
        waited = 0;
        bus.mem_ack_in = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            bus.mem_ack_in = stray_ack;
            if (bus.mem_req_out) begin
                if (waited >= ack_delay) begin
                    bus.mem_ack_in = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // Row engine: completes two cycles after a start; non-zero results only on the first pass.
    initial begin
        int lat;
        logic first;
        lat = 0;
        bus.eval_done_in = 1'b0;
        bus.eval_changed_in = 1'b0;
        bus.eval_count_in = '0;
        forever begin
            @(negedge clock);
            #1;
            bus.eval_done_in = stray_eval;
            bus.eval_changed_in = stray_eval;
            bus.eval_count_in = stray_eval ? CW'(77) : '0;
            if (reset) begin
                lat = 0;
            end else if (bus.eval_start_out) begin
                lat = 2;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    first = (pass_cnt_out == 16'd0);
                    bus.eval_done_in = 1'b1;
                    bus.eval_changed_in = first ? chg_first : 1'b0;
                    bus.eval_count_in = first ? cnt_first : '0;
                end
            end
        end
    end

    // Monitor: scoreboard of window/memory events plus request protocol checks.
    initial begin
        logic prev_req;
        logic prev_ack;
        logic prev_we;
        logic [AW-1:0] prev_row;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_we = 1'b0;
        prev_row = '0;
        forever begin
            @(negedge clock);
            #2;
            if (bus.win_zero_out) expect_ev("ev_zero", EV_ZERO);
            if (prev_req && prev_ack) begin
                check("req_drop_after_ack", bus.mem_req_out, 0);
            end else if (bus.mem_req_out && !prev_req) begin
                check("req_while_busy", bus.mem_busy_in, 0);
                expect_ev("ev_mem", (bus.mem_we_out ? EV_WRITE : EV_READ) + int'(bus.mem_row_out));
                if (bus.mem_we_out) n_writes++;
                else n_reads++;
            end else if (bus.mem_req_out) begin
                check("req_we_stable", bus.mem_we_out, prev_we);
                check("req_row_stable", bus.mem_row_out, prev_row);
            end
            if (bus.win_shift_out) expect_ev("ev_shift", EV_SHIFT);
            if (bus.eval_start_out) expect_ev("ev_eval", EV_EVAL);
            prev_req = bus.mem_req_out;
            prev_ack = bus.mem_ack_in;
            prev_we = bus.mem_we_out;
            prev_row = bus.mem_row_out;
        end
    end

    initial begin
        int r0, w0, passes, n;
        logic hit;
        reset = 1'b1;
        run_in = 1'b0;
        rows_in = '0;
        bus.mem_busy_in = 1'b0;
        cyc(3);
        #3;
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_updates", updates_out, 0);
        check("rst_pass", pass_cnt_out, 0);
        check("rst_req", bus.mem_req_out, 0);
        check("rst_zero", bus.win_zero_out, 0);
        check("rst_shift", bus.win_shift_out, 0);
        check("rst_eval", bus.eval_start_out, 0);
        cyc(1);
        reset = 1'b0;

        // A: three rows, first pass removes 2 per row and reports change
        cnt_first = CW'(2);
        chg_first = 1'b1;
        passes = (MULTI != 0) ? 2 : 1;
        for (int p = 0; p < passes; p++) push_pass(3);
        r0 = n_reads;
        w0 = n_writes;
        cyc(1);
        rows_in = 3;
        run_in = 1'b1;
        cyc(1);
        run_in = 1'b0;
        #3;
        check("A_busy", busy_out, 1);
        check("A_done_low", done_out, 0);
        cyc(6);
        rows_in = 1;
        run_in = 1'b1;
        cyc(1);
        run_in = 1'b0;
        wait_done("A", 3000);
        #3;
        check("A_updates", updates_out, 6);
        check("A_pass", pass_cnt_out, passes);
        check("A_reads", n_reads - r0, 3 * passes);
        check("A_writes", n_writes - w0, 3 * passes);
        check("A_busy_end", busy_out, 0);
        check("A_queue_empty", exp_q.size(), 0);

        // Stray ack / eval completion while finished must change nothing
        cyc(1);
        stray_ack = 1'b1;
        stray_eval = 1'b1;
        cyc(1);
        stray_ack = 1'b0;
        stray_eval = 1'b0;
        cyc(3);
        #3;
        check("S_updates", updates_out, 6);
        check("S_pass", pass_cnt_out, passes);
        check("S_done", done_out, 1);
        check("S_req", bus.mem_req_out, 0);

        // B: single row, no change
        cnt_first = '0;
        chg_first = 1'b0;
        push_pass(1);
        r0 = n_reads;
        w0 = n_writes;
        cyc(1);
        rows_in = 1;
        run_in = 1'b1;
        cyc(1);
        run_in = 1'b0;
        wait_done("B", 2000);
        #3;
        check("B_updates", updates_out, 0);
        check("B_pass", pass_cnt_out, 1);
        check("B_reads", n_reads - r0, 1);
        check("B_writes", n_writes - w0, 1);
        check("B_queue_empty", exp_q.size(), 0);

        // C: slow acks and memory busy at start
        ack_delay = 5;
        cnt_first = CW'(1);
        chg_first = 1'b0;
        push_pass(2);
        r0 = n_reads;
        w0 = n_writes;
        cyc(1);
        bus.mem_busy_in = 1'b1;
        rows_in = 2;
        run_in = 1'b1;
        cyc(1);
        run_in = 1'b0;
        #3;
        check("C_req_busy1", bus.mem_req_out, 0);
        cyc(1);
        #3;
        check("C_req_busy2", bus.mem_req_out, 0);
        cyc(1);
        bus.mem_busy_in = 1'b0;
        #3;
        check("C_req_free", bus.mem_req_out, 1);
        check("C_req_row", bus.mem_row_out, 0);
        check("C_req_we", bus.mem_we_out, 0);
        wait_done("C", 3000);
        #3;
        check("C_updates", updates_out, 2);
        check("C_pass", pass_cnt_out, 1);
        check("C_reads", n_reads - r0, 2);
        check("C_writes", n_writes - w0, 2);
        check("C_queue_empty", exp_q.size(), 0);
        ack_delay = 1;

        // D: zero rows finishes at once with no memory traffic
        r0 = n_reads + n_writes;
        cyc(1);
        rows_in = 0;
        run_in = 1'b1;
        cyc(1);
        run_in = 1'b0;
        cyc(1);
        #3;
        check("D_done", done_out, 1);
        check("D_busy", busy_out, 0);
        check("D_updates", updates_out, 0);
        check("D_pass", pass_cnt_out, 0);
        check("D_no_mem", n_reads + n_writes - r0, 0);

        // E: reset during write-back of row 1, then a clean restart
        cnt_first = CW'(1);
        chg_first = 1'b1;
        push_pass(3);
        cyc(1);
        rows_in = 3;
        run_in = 1'b1;
        cyc(1);
        run_in = 1'b0;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 500) begin
            cyc(1);
            #3;
            if (bus.mem_req_out && bus.mem_we_out && bus.mem_row_out == 1) hit = 1'b1;
            n++;
        end
        check("E_reach_wback1", hit, 1);
        reset = 1'b1;
        cyc(1);
        #3;
        check("E_rst_busy", busy_out, 0);
        check("E_rst_done", done_out, 0);
        check("E_rst_updates", updates_out, 0);
        check("E_rst_pass", pass_cnt_out, 0);
        check("E_rst_req", bus.mem_req_out, 0);
        check("E_rst_we", bus.mem_we_out, 0);
        check("E_rst_zero", bus.win_zero_out, 0);
        check("E_rst_eval", bus.eval_start_out, 0);
        exp_q.delete();
        r0 = n_reads + n_writes;
        cyc(1);
        reset = 1'b0;
        stray_ack = 1'b1;
        cyc(1);
        stray_ack = 1'b0;
        cyc(2);
        #3;
        check("E_no_req", bus.mem_req_out, 0);
        check("E_no_mem", n_reads + n_writes - r0, 0);
        cnt_first = CW'(1);
        chg_first = 1'b0;
        push_pass(2);
        r0 = n_reads;
        w0 = n_writes;
        cyc(1);
        rows_in = 2;
        run_in = 1'b1;
        cyc(1);
        run_in = 1'b0;
        wait_done("E", 2000);
        #3;
        check("E_updates", updates_out, 2);
        check("E_pass", pass_cnt_out, 1);
        check("E_reads", n_reads - r0, 2);
        check("E_writes", n_writes - w0, 2);
        check("E_queue_empty", exp_q.size(), 0);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
